// File: rtl/binary_frame_stream_gen.sv
// binary_frame_stream_gen
// Replays a stored 1-bit image as one framed vsync/href/clken/pixel stream per
// start pulse. Pixels come from a sync-read memory. Every stream output is
// registered once, so the outputs land in the same cycle as the memory read data.
module binary_frame_stream_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int H_BLANK   = 16,
  parameter int V_FRONT   = 4,
  parameter int V_BACK    = 4,
  parameter int CLKEN_DIV = 2,
  parameter int ADDR_W    = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_data,
  output logic              out_frame_vsync,
  output logic              out_frame_href,
  output logic              out_frame_clken,
  output logic              out_img_bit
);

  localparam int HACT_CYC = H_ACTIVE * CLKEN_DIV;
  localparam int LINE_LEN = HACT_CYC + H_BLANK;
  localparam int CW       = $clog2(LINE_LEN + 1);
  localparam int VMAX_A   = (V_FRONT > V_BACK) ? V_FRONT : V_BACK;
  localparam int VMAX     = (VMAX_A > V_ACTIVE) ? VMAX_A : V_ACTIVE;
  localparam int LW       = $clog2(VMAX + 1);
  localparam int DW       = (CLKEN_DIV > 1) ? $clog2(CLKEN_DIV) : 1;

  localparam logic [CW-1:0] C_LINE_LAST = CW'(LINE_LEN - 1);
  localparam logic [CW-1:0] C_ACT_LAST  = CW'(HACT_CYC - 1);
  localparam logic [LW-1:0] VF_LAST     = LW'(V_FRONT - 1);
  localparam logic [LW-1:0] VA_LAST     = LW'(V_ACTIVE - 1);
  localparam logic [LW-1:0] VB_LAST     = LW'(V_BACK - 1);
  localparam logic [DW-1:0] D_LAST      = DW'(CLKEN_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_V_PRE, S_ACT, S_HBLK, S_V_POST
  } state_t;

  state_t              r_state, w_state_next;
  logic [CW-1:0]       r_cnt, w_cnt_next;       // cycle within the current line
  logic [LW-1:0]       r_lcnt, w_lcnt_next;     // line within the current phase
  logic [DW-1:0]       r_div, w_div_next;       // pixel divider inside href
  logic [ADDR_W-1:0]   r_addr;
  logic                r_busy, r_done;
  logic                r_vsync, r_href, r_clken, r_bit_hold;
  logic                w_start_ok, w_line_end;
  logic                w_vsync, w_href, w_clken;

  // A start is only honoured when fully idle, including the done cycle.
  assign w_start_ok = start && (r_state == S_IDLE) && !r_busy;
  assign w_line_end = (r_cnt == C_LINE_LAST);

  // Internal (pre-register) stream strobes.
  assign w_vsync = (r_state != S_IDLE);
  assign w_href  = (r_state == S_ACT);
  assign w_clken = w_href && (r_div == '0);

  assign mem_rd_en   = w_clken;
  assign mem_rd_addr = r_addr;

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_lcnt  <= '0;
      r_div   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_lcnt  <= w_lcnt_next;
      r_div   <= w_div_next;
    end
  end

  // Next-state and counter logic for the frame sequencer.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + CW'(1);
    w_lcnt_next  = r_lcnt;
    case (r_state)
      S_IDLE: begin
        w_cnt_next = '0;
        if (w_start_ok) begin
          w_lcnt_next  = '0;
          w_state_next = (V_FRONT > 0) ? S_V_PRE : S_ACT;
        end
      end
      S_V_PRE: begin
        if (w_line_end) begin
          w_cnt_next = '0;
          if (r_lcnt == VF_LAST) begin
            w_lcnt_next  = '0;
            w_state_next = S_ACT;
          end else begin
            w_lcnt_next = r_lcnt + LW'(1);
          end
        end
      end
      S_ACT, S_HBLK: begin
        if (w_line_end) begin
          // With H_BLANK=0 the active part ends exactly on the line end.
          w_cnt_next = '0;
          if (r_lcnt == VA_LAST) begin
            w_lcnt_next  = '0;
            w_state_next = (V_BACK > 0) ? S_V_POST : S_IDLE;
          end else begin
            w_lcnt_next  = r_lcnt + LW'(1);
            w_state_next = S_ACT;
          end
        end else if (r_state == S_ACT && r_cnt == C_ACT_LAST) begin
          w_state_next = S_HBLK;
        end
      end
      S_V_POST: begin
        if (w_line_end) begin
          w_cnt_next = '0;
          if (r_lcnt == VB_LAST) begin
            w_lcnt_next  = '0;
            w_state_next = S_IDLE;
          end else begin
            w_lcnt_next = r_lcnt + LW'(1);
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
        w_lcnt_next  = '0;
      end
    endcase
  end

  // Divider runs only while staying in ACT, so every ACT entry starts at 0.
  always_comb begin
    w_div_next = '0;
    if (r_state == S_ACT && w_state_next == S_ACT)
      w_div_next = (r_div == D_LAST) ? '0 : r_div + DW'(1);
  end

  // Read address: cleared on frame start, bumped after each read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_addr <= '0;
    else if (w_start_ok)
      r_addr <= '0;
    else if (w_clken)
      r_addr <= r_addr + ADDR_W'(1);
  end

  // Output stage, busy and done tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsync    <= 1'b0;
      r_href     <= 1'b0;
      r_clken    <= 1'b0;
      r_bit_hold <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_vsync    <= w_vsync;
      r_href     <= w_href;
      r_clken    <= w_clken;
      r_bit_hold <= out_img_bit;
      r_done     <= r_vsync && !w_vsync;
      if (w_start_ok)
        r_busy <= 1'b1;
      else if (r_done)
        r_busy <= 1'b0;
    end
  end

  // Pixel takes read data on the strobe, holds it between strobes, zero outside href.
  assign out_img_bit     = r_href ? (r_clken ? mem_rd_data : r_bit_hold) : 1'b0;
  assign out_frame_vsync = r_vsync;
  assign out_frame_href  = r_href;
  assign out_frame_clken = r_clken;
  assign busy            = r_busy;
  assign done            = r_done;

endmodule

// File: tb/tb_binary_frame_stream_gen.sv
// Bench for binary_frame_stream_gen: three instances (CLKEN_DIV=2, CLKEN_DIV=1,
// no vertical porches) are compared every cycle against a cycle-index model.
module tb_binary_frame_stream_gen;

  localparam int HA = 4, VA = 3, HB = 2, AW = 19, NPIX = HA * VA;
  localparam int VF_T [3] = '{1, 1, 0};
  localparam int VB_T [3] = '{1, 1, 0};
  localparam int DV_T [3] = '{2, 1, 2};
  localparam int KMAX = 56;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] start_v = 3'b000;
  logic bz [3], dn [3], rden [3], vs [3], hr [3], ck [3], bt [3];
  logic [AW-1:0] addr [3];
  logic [2:0] rdat = 3'b000;
  logic mem [3][NPIX];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      binary_frame_stream_gen #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .V_FRONT(VF_T[gi]),
        .V_BACK(VB_T[gi]), .CLKEN_DIV(DV_T[gi]), .ADDR_W(AW)
      ) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start_v[gi]),
        .busy(bz[gi]), .done(dn[gi]), .mem_rd_en(rden[gi]),
        .mem_rd_addr(addr[gi]), .mem_rd_data(rdat[gi]),
        .out_frame_vsync(vs[gi]), .out_frame_href(hr[gi]),
        .out_frame_clken(ck[gi]), .out_img_bit(bt[gi])
      );
    end
  endgenerate

  // Sync-read image memories.
  always @(posedge clk) begin
    for (int c = 0; c < 3; c++)
      if (rden[c] && addr[c] < AW'(NPIX)) rdat[c] <= mem[c][int'(addr[c])];
  end

  typedef struct packed {
    logic vs, hr, ck, bt, dn, bz;
  } exp_t;

  // Expected outputs k cycles after the start-sampling edge (k=1 is first cycle after).
  function automatic int pix(int c, int k);
    int len, j;
    len = HA * DV_T[c] + HB;
    j = k - 2;
    if (j < 0) return 0;
    return ((j / len) - VF_T[c]) * HA + (j % len) / DV_T[c];
  endfunction

  function automatic exp_t model(int c, int k);
    exp_t e;
    int len, n, j, line, pos;
    len = HA * DV_T[c] + HB;
    n = (VF_T[c] + VA + VB_T[c]) * len;
    j = k - 2;
    e = '0;
    e.vs = (j >= 0) && (j < n);
    if (e.vs) begin
      line = j / len;
      pos = j % len;
      e.hr = (line >= VF_T[c]) && (line < VF_T[c] + VA) && (pos < HA * DV_T[c]);
      e.ck = e.hr && (pos % DV_T[c] == 0);
      e.bt = e.hr ? mem[c][pix(c, k)] : 1'b0;
    end
    e.dn = (j == n);
    e.bz = (k >= 1) && (j <= n);
    return e;
  endfunction

  task automatic chk(string tag, int c, int k, int obs, int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s inst%0d k=%0d observed=%0d expected=%0d", tag, c, k, obs, exp);
    end
  endtask

  task automatic chk_idle(string tag);
    for (int c = 0; c < 3; c++) begin
      chk({tag, "_vsync"}, c, 0, int'(vs[c]), 0);
      chk({tag, "_href"},  c, 0, int'(hr[c]), 0);
      chk({tag, "_clken"}, c, 0, int'(ck[c]), 0);
      chk({tag, "_bit"},   c, 0, int'(bt[c]), 0);
      chk({tag, "_done"},  c, 0, int'(dn[c]), 0);
      chk({tag, "_busy"},  c, 0, int'(bz[c]), 0);
      chk({tag, "_rden"},  c, 0, int'(rden[c]), 0);
    end
  endtask

  // Runs one frame on all instances; optional ignored start pulses; optional reset abort.
  task automatic run_frame(input bit pulses, input int abort_k, input string name);
    exp_t e, er;
    int nclk;
    int nfr;
    nclk = 0;
    @(negedge clk);
    start_v = 3'b111;
    @(posedge clk);
    #1;
    start_v = 3'b000;
    for (int k = 1; k <= KMAX; k++) begin
      if (k == abort_k) begin
        rst_n = 1'b0;
        #1;
        chk_idle("abort");
        for (int c = 0; c < 3; c++) chk("abort_addr", c, k, int'(addr[c]), 0);
        $display("%s: reset asserted at k=%0d", name, k);
        return;
      end
      for (int c = 0; c < 3; c++) begin
        e = model(c, k);
        er = model(c, k + 1);
        chk("vsync", c, k, int'(vs[c]), int'(e.vs));
        chk("href",  c, k, int'(hr[c]), int'(e.hr));
        chk("clken", c, k, int'(ck[c]), int'(e.ck));
        chk("bit",   c, k, int'(bt[c]), int'(e.bt));
        chk("done",  c, k, int'(dn[c]), int'(e.dn));
        chk("busy",  c, k, int'(bz[c]), int'(e.bz));
        chk("rd_en", c, k, int'(rden[c]), int'(er.ck));
        if (er.ck) chk("rd_addr", c, k, int'(addr[c]), pix(c, k + 1));
        nfr = (VF_T[c] + VA + VB_T[c]) * (HA * DV_T[c] + HB);
        if (pulses && (k == 10 || k == nfr + 2)) start_v[c] = 1'b1;
      end
      if (ck[0]) nclk++;
      @(posedge clk);
      #1;
      start_v = 3'b000;
    end
    chk("clken_count", 0, KMAX, nclk, NPIX);
    $display("%s: frame of %0d cycles checked", name, KMAX);
  endtask

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset");
    for (int c = 0; c < 3; c++) chk("reset_addr", c, 0, int'(addr[c]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset released");

    // Fixed pattern 1010_0110_1111, with ignored mid-frame and done-cycle starts.
    begin
      logic [11:0] pat;
      pat = 12'b1010_0110_1111;
      for (int c = 0; c < 3; c++)
        for (int i = 0; i < NPIX; i++) mem[c][i] = pat[11 - i];
    end
    run_frame(1'b1, 0, "pattern");

    // Start right after done: identical second frame from address 0.
    run_frame(1'b0, 0, "repeat");

    // Random images.
    for (int c = 0; c < 3; c++)
      for (int i = 0; i < NPIX; i++) mem[c][i] = 1'($urandom_range(0, 1));
    run_frame(1'b0, 0, "random1");

    // Abort during active line 2 of the DIV=2 instance.
    run_frame(1'b0, 25, "abort");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk_idle("post_abort");
    end
    $display("post_abort: no done observed window checked");

    for (int c = 0; c < 3; c++)
      for (int i = 0; i < NPIX; i++) mem[c][i] = 1'($urandom_range(0, 1));
    run_frame(1'b1, 0, "random2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
